lb_sequencer: RTL and testbench

- Sequences the four sprite line buffers (BL, BR, TL, TR) feeding the palette address path.
- Each scanline, one bank (pair of buffers) is read out and cleared toward the palette mux while the other bank is written by the sprite renderer.
- Generates TMS0, LD1/LD2, SS1/SS2, CK[3:0] and WE[3:0].
- Accepts sprite-strip write jobs from the renderer over a request/ack handshake and a per-pixel-pair valid/ready handshake.

---
 rtl/lb_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_lb_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_sequencer.sv
// -----------------------------------------------------------------------------
// lb_sequencer
//
// Sequences the four sprite line buffers (BL, BR, TL, TR) that feed the
// palette address path. On every scanline one bank (a pair of buffers) is read
// out and cleared toward the palette mux while the other bank is written by the
// sprite renderer. The banks swap at every line wrap via TMS0.
//
// Optional feature macro: LB_OVERRUN_EN
//   When defined, adds OVERRUN_CNT (saturating count of aborted render jobs)
//   and OVERRUN_LINE (sticky flag: the last line ended with an abort).
//
// Ports
//   CLK          in   system clock, shared with the line buffer RAM
//   RST          in   synchronous active-high reset (overrides CE_PIX)
//   CE_PIX       in   pixel enable; every counter and strobe advances only here
//   JOB_REQ      in   render job request, held until JOB_ACK
//   JOB_LEN      in   pixel pairs in the job (0 is acked and completes at once)
//   JOB_ACK      out  one-CLK pulse: job accepted
//   PX_VALID     in   renderer presents a pixel pair on GAD/GBD
//   PX_READY     out  one-CLK pulse: the presented pair was written
//   JOB_DONE     out  one-CLK pulse: last pair written (or zero-length job)
//   JOB_ABORT    out  one-CLK pulse: job killed by the line wrap
//   H_CNT        out  current pixel count, 0 .. H_TOTAL-1
//   TMS0         out  bank select: 0 = B displayed / T rendered, 1 = reverse
//   LD1, LD2     out  address load strobes for bank B and bank T
//   SS1, SS2     out  clear-after-read enables for bank B and bank T
//   CK[3:0]      out  address clock strobes, [0]=BL [1]=BR [2]=TL [3]=TR
//   WE[3:0]      out  write strobes, same index order as CK
//   OVERRUN_CNT  out  (LB_OVERRUN_EN only) saturating abort counter
//   OVERRUN_LINE out  (LB_OVERRUN_EN only) sticky abort-in-last-line flag
//   DBG_STATE    out  render FSM state: 0 = IDLE, 1 = LOAD, 2 = WRITE
//
// Handshakes
//   Job:   the renderer raises JOB_REQ with JOB_LEN stable and holds both until
//          it sees JOB_ACK. JOB_LEN is captured on the CE_PIX edge that raises
//          JOB_ACK. A request on the wrap cycle is not taken; it stays pending.
//   Pixel: a pair is consumed on a CE_PIX edge where the FSM is writing and
//          PX_VALID is high. PX_READY is registered, so it is high during the
//          CLK after the consuming edge; the renderer advances its pair then.
//
// All strobes are registered and are high for exactly one CLK following the
// CE_PIX edge that produced them. Display strobes are decoded from the next
// H count so that they line up with the H_CNT value shown alongside them.
// -----------------------------------------------------------------------------
module lb_sequencer #(
   parameter int H_TOTAL        = 384,
   parameter int H_ACTIVE_START = 30,
   parameter int H_ACTIVE_END   = 350,
   parameter int LEN_W          = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CE_PIX,
   input  logic             JOB_REQ,
   input  logic [LEN_W-1:0] JOB_LEN,
   output logic             JOB_ACK,
   input  logic             PX_VALID,
   output logic             PX_READY,
   output logic             JOB_DONE,
   output logic             JOB_ABORT,
   output logic [8:0]       H_CNT,
   output logic             TMS0,
   output logic             LD1,
   output logic             LD2,
   output logic             SS1,
   output logic             SS2,
   output logic [3:0]       CK,
   output logic [3:0]       WE,
`ifdef LB_OVERRUN_EN
   output logic [7:0]       OVERRUN_CNT,
   output logic             OVERRUN_LINE,
`endif
   output logic [1:0]       DBG_STATE
);

   localparam logic [8:0]       H_LAST    = 9'(H_TOTAL - 1);
   localparam logic [8:0]       H_START   = 9'(H_ACTIVE_START);
   localparam logic [8:0]       H_END     = 9'(H_ACTIVE_END);
   localparam logic [8:0]       H_PRELOAD = 9'(H_ACTIVE_START - 1);
   localparam logic [LEN_W-1:0] REM_ONE   = LEN_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_WRITE = 2'd2
   } state_e;

   state_e           state_q;
   logic [LEN_W-1:0] rem_q;

   // Next-line-position decode shared by the display and render paths.
   logic       wrap;
   logic [8:0] h_d;
   logic       tms_d;
   logic       win_d;
   logic       disp_ld_d;
   logic       disp_l_d;
   logic       disp_r_d;

   // Render-side fire conditions. A wrap edge kills the job, so neither fires
   // on it; that is what keeps WE off during the wrap cycle.
   logic ren_ld;
   logic ren_wr;
   logic ren_b;
   logic ren_t;

   assign wrap      = (H_CNT == H_LAST);
   assign h_d       = wrap ? 9'd0 : (H_CNT + 9'd1);
   assign tms_d     = TMS0 ^ wrap;
   assign win_d     = (h_d >= H_START) && (h_d < H_END);
   assign disp_ld_d = (h_d == H_PRELOAD);
   assign disp_l_d  = win_d & ~h_d[0];
   assign disp_r_d  = win_d &  h_d[0];

   assign ren_ld = (state_q == S_LOAD)  && !wrap && (rem_q != '0);
   assign ren_wr = (state_q == S_WRITE) && !wrap && PX_VALID;

   // The render bank is the one not displayed. Render strobes never fire on a
   // wrap edge, so the current TMS0 always equals the post-edge TMS0 here.
   assign ren_b = TMS0;
   assign ren_t = ~TMS0;

   assign DBG_STATE = state_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         rem_q     <= '0;
         H_CNT     <= '0;
         TMS0      <= 1'b0;
         LD1       <= 1'b0;
         LD2       <= 1'b0;
         SS1       <= 1'b0;
         SS2       <= 1'b0;
         CK        <= '0;
         WE        <= '0;
         JOB_ACK   <= 1'b0;
         JOB_DONE  <= 1'b0;
         JOB_ABORT <= 1'b0;
         PX_READY  <= 1'b0;
`ifdef LB_OVERRUN_EN
         OVERRUN_CNT  <= '0;
         OVERRUN_LINE <= 1'b0;
`endif
      end else begin
         // Strobes drop back to 0 on every CLK unless re-fired by CE_PIX.
         LD1       <= 1'b0;
         LD2       <= 1'b0;
         CK        <= '0;
         WE        <= '0;
         JOB_ACK   <= 1'b0;
         JOB_DONE  <= 1'b0;
         JOB_ABORT <= 1'b0;
         PX_READY  <= 1'b0;

         if (CE_PIX) begin
            H_CNT <= h_d;
            TMS0  <= tms_d;

            // SS is a level across the active window of the display bank.
            SS1 <= win_d & ~tms_d;
            SS2 <= win_d &  tms_d;

            LD1 <= (disp_ld_d & ~tms_d) | (ren_ld & ren_b);
            LD2 <= (disp_ld_d &  tms_d) | (ren_ld & ren_t);

            // Display L buffer on even counts, R buffer on odd counts; the
            // render path clocks both buffers of its bank together.
            CK <= {(disp_r_d &  tms_d) | (ren_wr & ren_t),
                   (disp_l_d &  tms_d) | (ren_wr & ren_t),
                   (disp_r_d & ~tms_d) | (ren_wr & ren_b),
                   (disp_l_d & ~tms_d) | (ren_wr & ren_b)};

            WE <= {ren_wr & ren_t, ren_wr & ren_t,
                   ren_wr & ren_b, ren_wr & ren_b};

            case (state_q)
               S_IDLE: begin
                  // The wrap cycle is reserved for the bank swap.
                  if (JOB_REQ && !wrap) begin
                     JOB_ACK <= 1'b1;
                     rem_q   <= JOB_LEN;
                     state_q <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  if (wrap) begin
                     JOB_ABORT <= 1'b1;
                     state_q   <= S_IDLE;
                  end else if (rem_q == '0) begin
                     // Zero-length job: nothing to address, finish at once.
                     JOB_DONE <= 1'b1;
                     state_q  <= S_IDLE;
                  end else begin
                     state_q <= S_WRITE;
                  end
               end
               S_WRITE: begin
                  if (wrap) begin
                     JOB_ABORT <= 1'b1;
                     state_q   <= S_IDLE;
                  end else if (PX_VALID) begin
                     PX_READY <= 1'b1;
                     rem_q    <= rem_q - REM_ONE;
                     if (rem_q == REM_ONE) begin
                        JOB_DONE <= 1'b1;
                        state_q  <= S_IDLE;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase

`ifdef LB_OVERRUN_EN
            // Aborts only ever happen on a wrap edge, so each wrap settles the
            // flag for the line just finished: set on abort, cleared otherwise.
            if (wrap) begin
               if (state_q != S_IDLE) begin
                  if (OVERRUN_CNT != 8'hFF) begin
                     OVERRUN_CNT <= OVERRUN_CNT + 8'd1;
                  end
                  OVERRUN_LINE <= 1'b1;
               end else begin
                  OVERRUN_LINE <= 1'b0;
               end
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_lb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lb_sequencer
//
// Randomised bench for lb_sequencer. A reference model steps on every CE_PIX
// edge, derives the expected strobes from the line position and the job rules,
// and pushes one record per edge that should produce a strobe. A monitor on the
// falling edge pops a record whenever the DUT shows any strobe and compares the
// full output picture. A second queue holds the accepted job lengths so each
// finished job can be checked for its total number of writes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lb_sequencer;

   localparam int H_TOTAL = 384;
   localparam int H_START = 30;
   localparam int H_END   = 350;
   localparam int LEN_W   = 6;
   localparam int REC_W   = 27;

   // ---------------- clock / reset / DUT ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic             ce;
   logic             job_req;
   logic [LEN_W-1:0] job_len;
   logic             px_valid;
   logic             job_ack;
   logic             px_ready;
   logic             job_done;
   logic             job_abort;
   logic [8:0]       h_cnt;
   logic             tms0;
   logic             ld1;
   logic             ld2;
   logic             ss1;
   logic             ss2;
   logic [3:0]       ck;
   logic [3:0]       we;
   logic [1:0]       dbg_state;
`ifdef LB_OVERRUN_EN
   logic [7:0]       overrun_cnt;
   logic             overrun_line;
`endif

   always #5 clk = ~clk;

   lb_sequencer dut (
      .CLK       (clk),
      .RST       (rst),
      .CE_PIX    (ce),
      .JOB_REQ   (job_req),
      .JOB_LEN   (job_len),
      .JOB_ACK   (job_ack),
      .PX_VALID  (px_valid),
      .PX_READY  (px_ready),
      .JOB_DONE  (job_done),
      .JOB_ABORT (job_abort),
      .H_CNT     (h_cnt),
      .TMS0      (tms0),
      .LD1       (ld1),
      .LD2       (ld2),
      .SS1       (ss1),
      .SS2       (ss2),
      .CK        (ck),
      .WE        (we),
`ifdef LB_OVERRUN_EN
      .OVERRUN_CNT  (overrun_cnt),
      .OVERRUN_LINE (overrun_line),
`endif
      .DBG_STATE (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [REC_W-1:0] exp_q[$];
   int               job_q[$];
   int               err_cnt = 0;
   int               chk_cnt = 0;
   bit               mon_en  = 1'b0;

   // Reference model state: line position, bank, and job progress.
   int m_h           = 0;
   bit m_tms         = 1'b0;
   bit m_busy        = 1'b0;
   bit m_load        = 1'b0;
   int m_left        = 0;
   bit m_ack_now     = 1'b0;
   int m_abort_total = 0;

   int we_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   always @(posedge clk) begin : ref_model
      bit         wrap;
      int         nh;
      bit         ntms;
      int         db;
      int         rb;
      bit         win;
      logic [3:0] e_ck;
      logic [3:0] e_we;
      bit         e_ld1;
      bit         e_ld2;
      bit         e_ack;
      bit         e_done;
      bit         e_abort;
      bit         e_rdy;
      m_ack_now = 1'b0;
      if (rst) begin
         m_h    = 0;
         m_tms  = 1'b0;
         m_busy = 1'b0;
         m_load = 1'b0;
         m_left = 0;
      end else if (ce) begin
         wrap    = (m_h == H_TOTAL - 1);
         nh      = wrap ? 0 : m_h + 1;
         ntms    = m_tms ^ wrap;
         e_ck    = '0;
         e_we    = '0;
         e_ld1   = 1'b0;
         e_ld2   = 1'b0;
         e_ack   = 1'b0;
         e_done  = 1'b0;
         e_abort = 1'b0;
         e_rdy   = 1'b0;
         // Buffer index base: bank B is 0/1, bank T is 2/3.
         db  = ntms ? 2 : 0;
         rb  = m_tms ? 0 : 2;
         win = (nh >= H_START) && (nh < H_END);
         if (win) begin
            if (nh % 2 == 0) e_ck[db] = 1'b1;
            else             e_ck[db + 1] = 1'b1;
         end
         if (nh == H_START - 1) begin
            if (db == 0) e_ld1 = 1'b1;
            else         e_ld2 = 1'b1;
         end
         if (!m_busy) begin
            if (job_req && !wrap) begin
               e_ack     = 1'b1;
               m_busy    = 1'b1;
               m_load    = 1'b1;
               m_left    = int'(job_len);
               m_ack_now = 1'b1;
               job_q.push_back(m_left);
            end
         end else if (wrap) begin
            e_abort = 1'b1;
            m_busy  = 1'b0;
            m_abort_total++;
         end else if (m_load) begin
            m_load = 1'b0;
            if (m_left == 0) begin
               e_done = 1'b1;
               m_busy = 1'b0;
            end else if (rb == 0) begin
               e_ld1 = 1'b1;
            end else begin
               e_ld2 = 1'b1;
            end
         end else if (px_valid) begin
            e_rdy        = 1'b1;
            e_we[rb]     = 1'b1;
            e_we[rb + 1] = 1'b1;
            e_ck[rb]     = 1'b1;
            e_ck[rb + 1] = 1'b1;
            m_left--;
            if (m_left == 0) begin
               e_done = 1'b1;
               m_busy = 1'b0;
            end
         end
         m_h   = nh;
         m_tms = ntms;
         if (e_ld1 || e_ld2 || (|e_ck) || (|e_we) || e_ack || e_done || e_abort || e_rdy)
            exp_q.push_back({9'(nh), ntms, e_ld1, e_ld2, win && !ntms, win && ntms,
                             e_ck, e_we, e_ack, e_done, e_abort, e_rdy, !m_busy});
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      logic [REC_W-1:0] act;
      logic [REC_W-1:0] exp;
      int               exp_len;
      if (mon_en) begin
         act = {h_cnt, tms0, ld1, ld2, ss1, ss2, ck, we,
                job_ack, job_done, job_abort, px_ready, (dbg_state == 2'd0)};
         if (ld1 || ld2 || (|ck) || (|we) || job_ack || job_done || job_abort || px_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", 32'(act), 32'd0);
            end else begin
               exp = exp_q.pop_front();
               check("strobe_rec", 32'(act), 32'(exp));
            end
         end
         if (job_ack) we_cnt = 0;
         if (|we) we_cnt++;
         if (job_done || job_abort) begin
            if (job_q.size() == 0) begin
               check("job_q_underflow", {30'd0, job_done, job_abort}, 32'd0);
            end else begin
               exp_len = job_q.pop_front();
               if (job_done) check("job_we_count", we_cnt, exp_len);
               else check("abort_we_short", 32'(we_cnt < ((exp_len > 0) ? exp_len : 1)), 32'd1);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto_h(input int h, input bit t);
      int n;
      n  = 0;
      ce = 1'b1;
      while (!(m_h == h && m_tms == t) && n < 1000) begin
         step();
         n++;
      end
      check("goto_h_cnt", 32'(h_cnt), h);
      check("goto_tms0", 32'(tms0), 32'(t));
   endtask

   // Runs a job whose JOB_REQ/JOB_LEN are already set until it ends.
   // vmode: 0 = PX_VALID steady, 1 = toggled per CE cycle, 2 = random.
   task automatic job_wait(input int vmode, input bit ce_rand);
      int n;
      bit tog;
      bit acked;
      bit fin;
      n     = 0;
      tog   = 1'b1;
      acked = 1'b0;
      fin   = 1'b0;
      while (!fin && n < 2000) begin
         ce = ce_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
         case (vmode)
            0:       px_valid = 1'b1;
            1:       px_valid = tog;
            default: px_valid = ($urandom_range(0, 3) != 0);
         endcase
         step();
         n++;
         if (m_ack_now) begin
            job_req = 1'b0;
            acked   = 1'b1;
         end
         if (ce && acked) tog = ~tog;
         if (acked && !m_busy) fin = 1'b1;
      end
      if (fin) begin
         check("job_end_idle", 32'(dbg_state), 32'd0);
      end else begin
         chk_cnt++;
         err_cnt++;
         $display("FAIL job_timeout: job did not finish within 2000 clocks at t=%0t", $time);
      end
      job_req  = 1'b0;
      px_valid = 1'b0;
   endtask

   task automatic issue_job(input int len, input int vmode, input bit ce_rand);
      job_len = LEN_W'(len);
      job_req = 1'b1;
      job_wait(vmode, ce_rand);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int c0;
      int c1;
      int c2;
      int c3;
      int l1;
      int l2;
      int s1;
      int len;
      rst      = 1'b1;
      ce       = 1'b1;
      job_req  = 1'b0;
      job_len  = '0;
      px_valid = 1'b0;

      // Reset with CE_PIX held high.
      repeat (3) step();
      check("rst_h_cnt", 32'(h_cnt), 32'd0);
      check("rst_tms0", 32'(tms0), 32'd0);
      check("rst_strobes", {18'd0, ld1, ld2, ss1, ss2, ck, we, job_ack, job_done, job_abort, px_ready}, 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // One full line with TMS0=0 and no jobs.
      c0 = 0; c1 = 0; c2 = 0; c3 = 0; l1 = 0; l2 = 0; s1 = 0;
      for (int i = 0; i < H_TOTAL; i++) begin
         step();
         if (ck[0]) c0++;
         if (ck[1]) c1++;
         if (ck[2]) c2++;
         if (ck[3]) c3++;
         if (ld1)   l1++;
         if (ld2)   l2++;
         if (ss1)   s1++;
      end
      check("wrap_h_cnt", 32'(h_cnt), 32'd0);
      check("wrap_tms0", 32'(tms0), 32'd1);
      check("ck0_pulses", c0, (H_END - H_START) / 2);
      check("ck1_pulses", c1, (H_END - H_START) / 2);
      check("ck2_pulses", c2, 0);
      check("ck3_pulses", c3, 0);
      check("ld1_pulses", l1, 1);
      check("ld2_pulses", l2, 0);
      check("ss1_cycles", s1, H_END - H_START);

      // Job into bank B while T is displayed.
      issue_job(5, 0, 1'b0);

      // TMS0=0: steady-valid job of 4 pairs, then toggled-valid job of 3.
      goto_h(10, 1'b0);
      issue_job(4, 0, 1'b0);
      issue_job(3, 1, 1'b0);
      // Zero-length job: acked, then done.
      issue_job(0, 0, 1'b0);

      // Long job started late in the line is killed by the wrap.
      goto_h(370, 1'b0);
      issue_job(40, 0, 1'b0);
      check("abort_pulse", 32'(job_abort), 32'd1);
`ifdef LB_OVERRUN_EN
      check("overrun_cnt_1", 32'(overrun_cnt), 32'd1);
      check("overrun_line_set", 32'(overrun_line), 32'd1);
`endif

      // Request raised on the H=383 cycle: the wrap wins, ack comes one later.
      goto_h(383, 1'b1);
      job_len  = LEN_W'(8);
      job_req  = 1'b1;
      px_valid = 1'b1;
      ce       = 1'b1;
      step();
      check("req_on_wrap_no_ack", 32'(job_ack), 32'd0);
      check("req_on_wrap_h", 32'(h_cnt), 32'd0);
      check("req_on_wrap_tms0", 32'(tms0), 32'd0);
`ifdef LB_OVERRUN_EN
      check("overrun_line_clear", 32'(overrun_line), 32'd0);
`endif
      job_wait(0, 1'b0);

      // Random jobs with random CE_PIX, PX_VALID and gaps.
      for (int j = 0; j < 40; j++) begin
         repeat ($urandom_range(0, 30)) begin
            ce       = ($urandom_range(0, 2) != 0);
            px_valid = ($urandom_range(0, 1) != 0);
            step();
         end
         len = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 63));
         issue_job(len, 2, 1'b1);
      end

      // Drain and final bookkeeping.
      ce = 1'b1;
      repeat (4) step();
      @(negedge clk);
      #1;
      check("exp_q_drained", exp_q.size(), 0);
      check("job_q_drained", job_q.size(), 0);
`ifdef LB_OVERRUN_EN
      check("overrun_cnt_total", 32'(overrun_cnt), (m_abort_total > 255) ? 255 : m_abort_total);
`endif
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
      $display("Result: errors=%0d of %0d checks", err_cnt + 1, chk_cnt + 1);
      $fatal(1, "time limit");
   end

endmodule
